load_buffer_unit: RTL and testbench

- Single-entry load buffer between the address calculation unit (ACU) and data memory.
- Captures one valid load (address plus destination ROB tag) from the ACU.
- Holds the load until the ROB reports no older pending stores and memory is free, then issues a one-cycle read request.
- The ROB-facing and MEM-facing outputs are all registered.

---
 rtl/load_buffer_unit.sv | 115 +++++++++++
 tb/tb_load_buffer_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer_unit.sv
// load_buffer_unit
// ----------------
// Single-entry load buffer between the address calculation unit (ACU) and
// data memory. It captures one load (address plus destination ROB tag) and
// holds it until the ROB reports no older unresolved stores and memory is
// free. It then raises a one-cycle read request. All outputs are registered.
//
// Ports:
//   clock          system clock; all state updates on the rising edge
//   reset          synchronous, active-low reset
//   lb_packet_in   {valid, address, rd_tag} from the ACU
//   alloc_enable   ACU requests allocation of lb_packet_in
//   pending_stores from ROB; older stores unresolved, load must wait
//   mem_busy       from MEM; memory cannot accept a read
//   lb_packet_out  registered entry contents
//   full           entry occupied; ACU must not allocate
//   load_address   entry address, to ROB
//   load_rob_tag   entry rd_tag, to ROB
//   read_mem       one-cycle memory read request
//   issue_count    (only with LB_ISSUE_COUNT_EN) number of issued loads,
//                  wraps modulo 2^32
//
// Build option: define LB_ISSUE_COUNT_EN to add the issue_count port and its
// counter. Without it the block behaves identically, minus that port.

package lb_pkg;
  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;

  typedef struct packed {
    logic                   valid;
    logic [XLEN-1:0]        address;
    logic [ROB_TAG_LEN-1:0] rd_tag;
  } lb_packet_t;
endpackage

module load_buffer_unit
  import lb_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  lb_packet_t             lb_packet_in,
  input  logic                   alloc_enable,
  input  logic                   pending_stores,
  input  logic                   mem_busy,
  output lb_packet_t             lb_packet_out,
  output logic                   full,
  output logic [XLEN-1:0]        load_address,
  output logic [ROB_TAG_LEN-1:0] load_rob_tag,
  output logic                   read_mem
`ifdef LB_ISSUE_COUNT_EN
  ,
  output logic [31:0]            issue_count
`endif
);

  lb_packet_t entry_q, entry_d;
  logic       read_mem_q, read_mem_d;
  logic       do_alloc;
  logic       do_issue;

  // Both decisions look only at the registered entry, so a load allocated at
  // one edge can issue no earlier than the following edge, and an entry that
  // issues at an edge cannot be refilled at that same edge.
  assign do_alloc = !entry_q.valid && alloc_enable && lb_packet_in.valid;
  assign do_issue = entry_q.valid && !pending_stores && !mem_busy;

  // Issuing clears only the valid bit; address and tag stay visible so the
  // ROB and MEM still see the load that was just sent.
  always_comb begin
    entry_d    = entry_q;
    read_mem_d = do_issue;
    if (do_issue) begin
      entry_d.valid = 1'b0;
    end else if (do_alloc) begin
      entry_d       = lb_packet_in;
      entry_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      entry_q    <= '0;
      read_mem_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      read_mem_q <= read_mem_d;
    end
  end

`ifdef LB_ISSUE_COUNT_EN
  logic [31:0] issue_count_q, issue_count_d;

  always_comb begin
    issue_count_d = issue_count_q + 32'(do_issue);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      issue_count_q <= '0;
    end else begin
      issue_count_q <= issue_count_d;
    end
  end

  assign issue_count = issue_count_q;
`endif

  assign lb_packet_out = entry_q;
  assign full          = entry_q.valid;
  assign load_address  = entry_q.address;
  assign load_rob_tag  = entry_q.rd_tag;
  assign read_mem      = read_mem_q;

endmodule

// File: tb/tb_load_buffer_unit.sv
// tb_load_buffer_unit
// -------------------
// Drives the load buffer through a table of hand-derived vectors, a long
// blocking sequence, and randomized traffic compared against a reference
// model that treats the buffer as a one-slot queue of pending loads.

module tb_load_buffer_unit;
  import lb_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  lb_packet_t             lb_packet_in;
  logic                   alloc_enable;
  logic                   pending_stores;
  logic                   mem_busy;
  lb_packet_t             lb_packet_out;
  logic                   full;
  logic [XLEN-1:0]        load_address;
  logic [ROB_TAG_LEN-1:0] load_rob_tag;
  logic                   read_mem;
`ifdef LB_ISSUE_COUNT_EN
  logic [31:0]            issue_count;
`endif

  int test_count = 0;
  int fail_count = 0;

  // Reference model: a queue holding at most one pending load, the last
  // address/tag accepted, whether the previous edge issued, and an issue tally.
  lb_packet_t             m_q[$];
  logic [XLEN-1:0]        m_addr;
  logic [ROB_TAG_LEN-1:0] m_tag;
  logic                   m_read;
  logic [31:0]            m_count;

  typedef struct {
    logic                   rst;
    logic                   alloc;
    logic                   valid;
    logic [XLEN-1:0]        addr;
    logic [ROB_TAG_LEN-1:0] tag;
    logic                   ps;
    logic                   mb;
    logic                   e_full;
    logic [XLEN-1:0]        e_addr;
    logic [ROB_TAG_LEN-1:0] e_tag;
    logic                   e_read;
    logic [31:0]            e_count;
  } vec_t;

  vec_t vecs[$];

  load_buffer_unit dut (
    .clock          (clock),
    .reset          (reset),
    .lb_packet_in   (lb_packet_in),
    .alloc_enable   (alloc_enable),
    .pending_stores (pending_stores),
    .mem_busy       (mem_busy),
    .lb_packet_out  (lb_packet_out),
    .full           (full),
    .load_address   (load_address),
    .load_rob_tag   (load_rob_tag),
    .read_mem       (read_mem)
`ifdef LB_ISSUE_COUNT_EN
    ,
    .issue_count    (issue_count)
`endif
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  function automatic vec_t mkv(logic rst, logic alloc, logic valid, int addr, int tag,
                               logic ps, logic mb, logic e_full, int e_addr, int e_tag,
                               logic e_read, int e_count);
    vec_t v;
    v.rst     = rst;
    v.alloc   = alloc;
    v.valid   = valid;
    v.addr    = XLEN'(addr);
    v.tag     = ROB_TAG_LEN'(tag);
    v.ps      = ps;
    v.mb      = mb;
    v.e_full  = e_full;
    v.e_addr  = XLEN'(e_addr);
    v.e_tag   = ROB_TAG_LEN'(e_tag);
    v.e_read  = e_read;
    v.e_count = 32'(e_count);
    return v;
  endfunction

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelStep();
    bit had;
    if (!reset) begin
      m_q.delete();
      m_addr  = '0;
      m_tag   = '0;
      m_read  = 1'b0;
      m_count = '0;
    end else begin
      had    = (m_q.size() != 0);
      m_read = 1'b0;
      if (had && !pending_stores && !mem_busy) begin
        void'(m_q.pop_front());
        m_read  = 1'b1;
        m_count = m_count + 1;
      end else if (!had && alloc_enable && lb_packet_in.valid) begin
        m_q.push_back(lb_packet_in);
        m_addr = lb_packet_in.address;
        m_tag  = lb_packet_in.rd_tag;
      end
    end
  endtask

  // Drive one cycle of inputs, take the edge, then settle before sampling.
  task automatic applyStimulus(input logic rst, input logic alloc, input logic valid,
                               input logic [XLEN-1:0] addr, input logic [ROB_TAG_LEN-1:0] tag,
                               input logic ps, input logic mb);
    reset                = rst;
    alloc_enable         = alloc;
    lb_packet_in.valid   = valid;
    lb_packet_in.address = addr;
    lb_packet_in.rd_tag  = tag;
    pending_stores       = ps;
    mem_busy             = mb;
    @(posedge clock);
    modelStep();
    #1;
  endtask

  // Compare every output against the reference model.
  task automatic checkOutput(input string label);
    logic e_full;
    e_full = (m_q.size() != 0);
    compare({label, ".full"}, 64'(full), 64'(e_full));
    compare({label, ".load_address"}, 64'(load_address), 64'(m_addr));
    compare({label, ".load_rob_tag"}, 64'(load_rob_tag), 64'(m_tag));
    compare({label, ".read_mem"}, 64'(read_mem), 64'(m_read));
    compare({label, ".lb_packet_out"}, 64'(lb_packet_out), 64'({e_full, m_addr, m_tag}));
`ifdef LB_ISSUE_COUNT_EN
    compare({label, ".issue_count"}, 64'(issue_count), 64'(m_count));
`endif
  endtask

  // Compare every output against the hand-derived constants of one vector.
  task automatic checkVector(input int i, input vec_t v);
    string label;
    label = $sformatf("vec%0d", i);
    compare({label, ".full"}, 64'(full), 64'(v.e_full));
    compare({label, ".load_address"}, 64'(load_address), 64'(v.e_addr));
    compare({label, ".load_rob_tag"}, 64'(load_rob_tag), 64'(v.e_tag));
    compare({label, ".read_mem"}, 64'(read_mem), 64'(v.e_read));
    compare({label, ".lb_packet_out"}, 64'(lb_packet_out), 64'({v.e_full, v.e_addr, v.e_tag}));
`ifdef LB_ISSUE_COUNT_EN
    compare({label, ".issue_count"}, 64'(issue_count), 64'(v.e_count));
`endif
  endtask

  initial begin
    //                rst al vl addr tag ps mb | full addr tag read cnt
    vecs.push_back(mkv(0, 0, 0, 0,   0,  0, 0,   0,   0,   0,  0,   0)); // reset
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   0,   0,  0,   0)); // idle after reset
    vecs.push_back(mkv(1, 1, 0, 5,   1,  0, 0,   0,   0,   0,  0,   0)); // invalid packet ignored
    vecs.push_back(mkv(1, 1, 1, 5,   1,  0, 0,   1,   5,   1,  0,   0)); // allocate 5/1
    vecs.push_back(mkv(1, 0, 0, 0,   0,  1, 0,   1,   5,   1,  0,   0)); // held by pending stores
    vecs.push_back(mkv(1, 1, 1, 4,   2,  1, 0,   1,   5,   1,  0,   0)); // alloc while full ignored
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   5,   1,  1,   1)); // issue 5/1
    vecs.push_back(mkv(1, 1, 1, 2,   2,  0, 0,   1,   2,   2,  0,   1)); // allocate 2/2
    vecs.push_back(mkv(1, 1, 1, 6,   5,  0, 0,   0,   2,   2,  1,   2)); // issue; same-edge alloc dropped
    vecs.push_back(mkv(1, 1, 1, 4,   3,  0, 1,   1,   4,   3,  0,   2)); // allocate 4/3, mem busy
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 1,   1,   4,   3,  0,   2)); // still busy
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   4,   3,  1,   3)); // issue 4/3
    vecs.push_back(mkv(1, 1, 1, 3,   1,  1, 1,   1,   3,   1,  0,   3)); // allocate 3/1, both block
    vecs.push_back(mkv(1, 0, 0, 0,   0,  1, 0,   1,   3,   1,  0,   3)); // mem free, stores pending
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   3,   1,  1,   4)); // issue 3/1
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   3,   1,  0,   4)); // pulse ends
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   3,   1,  0,   4)); // idle hold
    vecs.push_back(mkv(1, 1, 1, 7,   6,  1, 0,   1,   7,   6,  0,   4)); // allocate 7/6, held
    vecs.push_back(mkv(0, 0, 0, 0,   0,  1, 0,   0,   0,   0,  0,   0)); // reset while full
    vecs.push_back(mkv(1, 1, 1, 9,   4,  0, 0,   1,   9,   4,  0,   0)); // allocate 9/4
    vecs.push_back(mkv(1, 0, 0, 0,   0,  0, 0,   0,   9,   4,  1,   1)); // issue 9/4
    vecs.push_back(mkv(0, 0, 0, 0,   0,  0, 0,   0,   0,   0,  0,   0)); // reset after issue edge

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].alloc, vecs[i].valid, vecs[i].addr,
                    vecs[i].tag, vecs[i].ps, vecs[i].mb);
      checkVector(i, vecs[i]);
    end

    // Reset landing exactly on the read_mem cycle drops the pulse.
    applyStimulus(1, 1, 1, 32'h0000_00aa, 5'd9, 0, 0);
    checkOutput("rstpulse.alloc");
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    compare("rstpulse.read_mem_before", 64'(read_mem), 64'd1);
    applyStimulus(0, 0, 0, '0, '0, 0, 0);
    checkOutput("rstpulse.reset");
    compare("rstpulse.read_mem_after", 64'(read_mem), 64'd0);

    // Long hold: memory busy for many cycles while stores toggle, then release.
    applyStimulus(1, 1, 1, 32'hdead_beef, 5'd31, 0, 1);
    checkOutput("hold.alloc");
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 1, 1, 32'(c), 5'(c), 1'($urandom_range(0, 1)), 1);
      checkOutput($sformatf("hold.c%0d", c));
    end
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    checkOutput("hold.release");
    compare("hold.read_mem", 64'(read_mem), 64'd1);
    compare("hold.addr", 64'(load_address), 64'h0000_0000_dead_beef);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0),
                    XLEN'($urandom()),
                    ROB_TAG_LEN'($urandom()),
                    ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 9) < 3));
      checkOutput($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
